// File: rtl/cdc_req_sender.sv
// cdc_req_sender
// Source-domain transmitter for a single-word clock-domain crossing using a
// four-phase req/ack handshake. A word accepted on the valid/ready port is
// registered onto o_cdc_data and held there while o_cdc_req is raised. The
// destination returns i_cdc_ack, which is synchronised here before it is
// allowed to influence any state. Everything below runs on i_clk.
//
// Handshake phases as seen from this side:
//   IDLE    : ready for a word; req low
//   REQ     : req high, waiting for the synchronised ack to go high
//   RELEASE : req low again, waiting for the synchronised ack to drop
// A transfer counts as complete only when the ack has fully returned low.
//
// SYNC_STAGES is meant to be 2..4; fewer than two flops gives no
// metastability protection and the chain slice below would be empty.

module cdc_req_sender #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_src_valid,
  output logic                  o_src_ready,
  input  logic [DATA_WIDTH-1:0] i_src_data,
  output logic [DATA_WIDTH-1:0] o_cdc_data,
  output logic                  o_cdc_req,
  input  logic                  i_cdc_ack,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_xfer_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } SenderState;

  SenderState             r_state;
  logic [SYNC_STAGES-1:0] r_ackSync;
  logic                   r_cdcReq;
  logic [DATA_WIDTH-1:0]  r_cdcData;
  logic [CNT_WIDTH-1:0]   r_xferCount;

  logic                   w_ackS;
  logic                   w_srcReady;

  // Plain flop chain bringing the asynchronous ack into i_clk; no logic between stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ackSync <= '0;
    end else begin
      r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], i_cdc_ack};
    end
  end

  assign w_ackS = r_ackSync[SYNC_STAGES-1];

  // Ready depends on the phase only, so the local producer never sees a path from its own valid.
  assign w_srcReady = (r_state == IDLE);

  // Handshake sequencer: captures the word, drives req and counts finished transfers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cdcReq    <= 1'b0;
      r_cdcData   <= '0;
      r_xferCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_src_valid && w_srcReady) begin
            r_cdcData <= i_src_data;
            r_cdcReq  <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (w_ackS) begin
            r_cdcReq <= 1'b0;
            r_state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (!w_ackS) begin
            r_xferCount <= r_xferCount + CNT_WIDTH'(1);
            r_state     <= IDLE;
          end
        end
        default: begin
          r_cdcReq <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign o_src_ready  = w_srcReady;
  assign o_busy       = !w_srcReady;
  assign o_cdc_req    = r_cdcReq;
  assign o_cdc_data   = r_cdcData;
  assign o_xfer_count = r_xferCount;

endmodule

// File: tb/tb_cdc_req_sender.sv
// tb_cdc_req_sender
// Two instances share one clock: index 0 uses a 2-flop ack synchroniser,
// index 1 a 3-flop one; both use a 4-bit transfer counter so wrap is quick.
// A transaction-level reference model tracks each instance and is compared
// against the outputs on every falling edge; directed tables and sequences
// add hand-derived expectations for the corner cases.

module tb_cdc_req_sender;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NI = 2;
  localparam int S0 = 2;
  localparam int S1 = 3;

  logic          clk = 1'b0;
  logic          rst       [NI];
  logic          srcValid  [NI];
  logic [DW-1:0] srcData   [NI];
  logic          cdcAck    [NI];
  logic          srcReady  [NI];
  logic [DW-1:0] cdcData   [NI];
  logic          cdcReq    [NI];
  logic          busy      [NI];
  logic [CW-1:0] xferCount [NI];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  cdc_req_sender #(.DATA_WIDTH(DW), .SYNC_STAGES(S0), .CNT_WIDTH(CW)) dut2 (
    .i_clk(clk), .i_rst(rst[0]), .i_src_valid(srcValid[0]), .o_src_ready(srcReady[0]),
    .i_src_data(srcData[0]), .o_cdc_data(cdcData[0]), .o_cdc_req(cdcReq[0]),
    .i_cdc_ack(cdcAck[0]), .o_busy(busy[0]), .o_xfer_count(xferCount[0])
  );

  cdc_req_sender #(.DATA_WIDTH(DW), .SYNC_STAGES(S1), .CNT_WIDTH(CW)) dut3 (
    .i_clk(clk), .i_rst(rst[1]), .i_src_valid(srcValid[1]), .o_src_ready(srcReady[1]),
    .i_src_data(srcData[1]), .o_cdc_data(cdcData[1]), .o_cdc_req(cdcReq[1]),
    .i_cdc_ack(cdcAck[1]), .o_busy(busy[1]), .o_xfer_count(xferCount[1])
  );

  // Reference model state: is a word in flight, has the destination's ack
  // been seen yet, which word, how many finished, and a history of raw ack
  // samples so the synchronised view is just "the sample N edges ago".
  bit            modelOn  [NI];
  bit            inFlight [NI];
  bit            ackSeen  [NI];
  logic [DW-1:0] mData    [NI];
  int            mCount   [NI];
  logic [7:0]    ackLog   [NI];

  function automatic int syncOf(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int i, input logic r, input logic v, input logic [DW-1:0] d, input logic a);
    rst[i]      = r;
    srcValid[i] = v;
    srcData[i]  = d;
    cdcAck[i]   = a;
  endtask

  // Advance the reference model on every rising edge from the inputs held across it.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit ackS;
      ackS = ackLog[i][syncOf(i)-1];
      if (rst[i] === 1'b1) begin
        inFlight[i] = 1'b0;
        ackSeen[i]  = 1'b0;
        mData[i]    = '0;
        mCount[i]   = 0;
        ackLog[i]   = '0;
        modelOn[i]  = 1'b1;
      end else begin
        if (!inFlight[i]) begin
          if (srcValid[i] === 1'b1) begin
            inFlight[i] = 1'b1;
            ackSeen[i]  = 1'b0;
            mData[i]    = srcData[i];
          end
        end else if (!ackSeen[i]) begin
          if (ackS) ackSeen[i] = 1'b1;
        end else if (!ackS) begin
          inFlight[i] = 1'b0;
          mCount[i]   = (mCount[i] + 1) % (1 << CW);
        end
        ackLog[i] = {ackLog[i][6:0], cdcAck[i]};
      end
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (modelOn[i]) begin
        checkOutput($sformatf("model%0d.src_ready", i), 64'(srcReady[i]), 64'(!inFlight[i]));
        checkOutput($sformatf("model%0d.busy", i), 64'(busy[i]), 64'(inFlight[i]));
        checkOutput($sformatf("model%0d.cdc_req", i), 64'(cdcReq[i]), 64'(inFlight[i] && !ackSeen[i]));
        checkOutput($sformatf("model%0d.cdc_data", i), 64'(cdcData[i]), 64'(mData[i]));
        checkOutput($sformatf("model%0d.xfer_count", i), 64'(xferCount[i]), 64'(mCount[i]));
      end
    end
  end

  typedef struct {
    logic          rst;
    logic          valid;
    logic [DW-1:0] data;
    logic          ack;
    logic          expReady;
    logic          expReq;
    logic [DW-1:0] expData;
    int            expCount;
  } Vector;

  Vector vecs[$];

  task automatic addVec(input logic r, input logic v, input logic [DW-1:0] d, input logic a,
                        input logic er, input logic eq, input logic [DW-1:0] ed, input int ec);
    Vector x;
    x.rst = r; x.valid = v; x.data = d; x.ack = a;
    x.expReady = er; x.expReq = eq; x.expData = ed; x.expCount = ec;
    vecs.push_back(x);
  endtask

  initial begin
    int            word;
    int            cyc;
    int            lastRise;
    int            rises;
    logic          prevReq;
    logic [CW-1:0] prevCount;
    logic [CW-1:0] seen[$];

    for (int i = 0; i < NI; i++) applyStimulus(i, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, '0, 1'b0);

    // Rows: inputs before an edge, outputs expected after it (instance 0, 2 sync flops).
    addVec(1, 0, 32'h0,        0, 1, 0, 32'h0,        0);
    addVec(1, 0, 32'h0,        0, 1, 0, 32'h0,        0);
    addVec(0, 1, 32'h0BADF00D, 0, 0, 1, 32'h0BADF00D, 0);
    addVec(0, 1, 32'h12345678, 0, 0, 1, 32'h0BADF00D, 0);
    addVec(1, 0, 32'h0,        0, 1, 0, 32'h0,        0);
    addVec(1, 0, 32'h0,        0, 1, 0, 32'h0,        0);
    addVec(0, 1, 32'hA5A50001, 0, 0, 1, 32'hA5A50001, 0);
    addVec(0, 1, 32'h11111111, 0, 0, 1, 32'hA5A50001, 0);
    addVec(0, 1, 32'h22222222, 0, 0, 1, 32'hA5A50001, 0);
    addVec(0, 1, 32'h33333333, 0, 0, 1, 32'hA5A50001, 0);
    addVec(0, 1, 32'h44444444, 1, 0, 1, 32'hA5A50001, 0);
    addVec(0, 1, 32'h55555555, 1, 0, 1, 32'hA5A50001, 0);
    addVec(0, 1, 32'h66666666, 1, 0, 0, 32'hA5A50001, 0);
    addVec(0, 1, 32'h77777777, 1, 0, 0, 32'hA5A50001, 0);
    addVec(0, 1, 32'h88888888, 1, 0, 0, 32'hA5A50001, 0);
    addVec(0, 1, 32'h99999999, 1, 0, 0, 32'hA5A50001, 0);
    addVec(0, 1, 32'hAAAAAAAA, 0, 0, 0, 32'hA5A50001, 0);
    addVec(0, 1, 32'hBBBBBBBB, 0, 0, 0, 32'hA5A50001, 0);
    addVec(0, 1, 32'hCCCCCCCC, 0, 1, 0, 32'hA5A50001, 1);
    addVec(0, 0, 32'hDDDDDDDD, 0, 1, 0, 32'hA5A50001, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(0, vecs[k].rst, vecs[k].valid, vecs[k].data, vecs[k].ack);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.src_ready", k), 64'(srcReady[0]), 64'(vecs[k].expReady));
      checkOutput($sformatf("vec%0d.busy", k), 64'(busy[0]), 64'(!vecs[k].expReady));
      checkOutput($sformatf("vec%0d.cdc_req", k), 64'(cdcReq[0]), 64'(vecs[k].expReq));
      checkOutput($sformatf("vec%0d.cdc_data", k), 64'(cdcData[0]), 64'(vecs[k].expData));
      checkOutput($sformatf("vec%0d.xfer_count", k), 64'(xferCount[0]), 64'(vecs[k].expCount));
    end

    // Back-to-back words 1..5 with a destination that echoes req straight back.
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    word = 1; cyc = 0; lastRise = -1; prevReq = 1'b0;
    while (mCount[0] != 5 && cyc < 300) begin
      applyStimulus(0, 1'b0, (word <= 5), DW'(word), cdcReq[0]);
      @(negedge clk);
      cyc++;
      if (cdcReq[0] && !prevReq) begin
        checkOutput($sformatf("b2b.word%0d", word), 64'(cdcData[0]), 64'(word));
        if (lastRise >= 0) checkOutput("b2b.spacing", 64'(cyc - lastRise), 64'(2 * S0 + 3));
        lastRise = cyc;
        word++;
      end
      prevReq = cdcReq[0];
    end
    checkOutput("b2b.xfer_count", 64'(xferCount[0]), 64'(5));
    checkOutput("b2b.words", 64'(word - 1), 64'(5));

    // Seventeen transfers on a 4-bit counter: every new count value is recorded.
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rises = 0; cyc = 0; prevReq = 1'b0; prevCount = '0; seen.delete();
    while (seen.size() < 17 && cyc < 17 * 12) begin
      applyStimulus(0, 1'b0, (rises < 17), $urandom, cdcReq[0]);
      @(negedge clk);
      cyc++;
      if (cdcReq[0] && !prevReq) rises++;
      prevReq = cdcReq[0];
      if (xferCount[0] !== prevCount) begin
        seen.push_back(xferCount[0]);
        prevCount = xferCount[0];
      end
    end
    checkOutput("wrap.transfers", 64'(seen.size()), 64'(17));
    for (int k = 0; k < seen.size(); k++)
      checkOutput($sformatf("wrap.count%0d", k + 1), 64'(seen[k]), 64'((k + 1) % 16));

    // One-clock ack pulse during REQ on the 3-flop instance.
    applyStimulus(1, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b1, 32'hC0FFEE01, 1'b0);
    @(negedge clk);
    checkOutput("glitch.reqRise", 64'(cdcReq[1]), 64'(1));
    checkOutput("glitch.data", 64'(cdcData[1]), 64'(32'hC0FFEE01));
    applyStimulus(1, 1'b0, 1'b1, 32'h00000001, 1'b0);
    @(negedge clk);
    checkOutput("glitch.holdData", 64'(cdcData[1]), 64'(32'hC0FFEE01));
    applyStimulus(1, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("glitch.edge1.req", 64'(cdcReq[1]), 64'(1));
    applyStimulus(1, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("glitch.edge2.req", 64'(cdcReq[1]), 64'(1));
    @(negedge clk);
    checkOutput("glitch.edge3.req", 64'(cdcReq[1]), 64'(1));
    @(negedge clk);
    checkOutput("glitch.edge4.req", 64'(cdcReq[1]), 64'(0));
    checkOutput("glitch.edge4.ready", 64'(srcReady[1]), 64'(0));
    @(negedge clk);
    checkOutput("glitch.edge5.ready", 64'(srcReady[1]), 64'(1));
    checkOutput("glitch.edge5.count", 64'(xferCount[1]), 64'(1));

    // Random traffic on both instances, including stray acks and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NI; i++) begin
        logic a;
        a = cdcAck[i];
        case ($urandom_range(0, 7))
          0, 1, 2: a = cdcReq[i];
          3:       a = ~a;
          default: a = cdcAck[i];
        endcase
        applyStimulus(i, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), $urandom, a);
      end
      @(negedge clk);
    end

    for (int i = 0; i < NI; i++) applyStimulus(i, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
